// File: rtl/npu_pkg.sv
//==============================================================================
// Module   : npu_pkg
// Purpose  : Types and default sizes shared by the NPU operand path
//            (vector packer and the pre-activation datapath).
// Contents : NPU_N, NPU_DATA_WIDTH, NPU_CNT_WIDTH default sizes
//            packer_state_t  packer FSM state encoding (FILL, FULL)
//            slot_t          element slot index at the default vector size
//            elem_t          signed element type at the default data width
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

package npu_pkg;

    localparam int NPU_N          = 4;
    localparam int NPU_DATA_WIDTH = 8;
    localparam int NPU_CNT_WIDTH  = $clog2(NPU_N);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } packer_state_t;

    typedef logic [NPU_CNT_WIDTH-1:0]         slot_t;
    typedef logic signed [NPU_DATA_WIDTH-1:0] elem_t;

endpackage

`default_nettype wire

// File: rtl/vector_packer.sv
//==============================================================================
// Module   : vector_packer
// Purpose  : Gathers a serial stream of x/w element pairs (one pair per beat)
//            plus a bias into one registered packed vector for the
//            pre-activation datapath. Slot i sits at [i*DATA_WIDTH +: DATA_WIDTH].
// Ports    : clk        clock, rising edge
//            rst        asynchronous reset, active-high
//            in_valid   element beat valid
//            in_ready   packer can take a beat (FILL state, not in reset)
//            in_x/in_w  element pair for the current slot
//            in_b       bias, sampled on the slot-0 beat only
//            in_last    early end of vector (VECTOR_PACKER_TLAST_EN only)
//            out_valid  packed vector held and valid
//            out_ready  downstream accepts the held vector
//            out_x/out_w/out_b  registered packed vectors and bias
// Config   : VECTOR_PACKER_TLAST_EN - adds in_last for short vectors
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module vector_packer
    import npu_pkg::*;
#(
    parameter int N          = NPU_N,
    parameter int DATA_WIDTH = NPU_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_x,
    input  logic [DATA_WIDTH-1:0]   in_w,
    input  logic [DATA_WIDTH-1:0]   in_b,
`ifdef VECTOR_PACKER_TLAST_EN
    input  logic                    in_last,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_x,
    output logic [N*DATA_WIDTH-1:0] out_w,
    output logic [DATA_WIDTH-1:0]   out_b
);

    localparam int                   CNT_WIDTH = $clog2(N);
    localparam logic [CNT_WIDTH-1:0] SLOT_MAX  = CNT_WIDTH'(N - 1);

    packer_state_t           r_state;
    packer_state_t           w_state_next;
    logic [CNT_WIDTH-1:0]    r_slot;
    logic [N*DATA_WIDTH-1:0] r_x;
    logic [N*DATA_WIDTH-1:0] r_w;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    w_beat;
    logic                    w_vec_end;

    // in_ready is gated by rst so no beat is offered while reset is held.
    assign in_ready  = ~rst & (r_state == FILL);
    assign out_valid = (r_state == FULL);
    assign w_beat    = in_valid & in_ready;

`ifdef VECTOR_PACKER_TLAST_EN
    assign w_vec_end = (r_slot == SLOT_MAX) | in_last;
`else
    assign w_vec_end = (r_slot == SLOT_MAX);
`endif

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic. Leaving FULL takes one cycle, so the first beat of
    // the next vector is accepted no earlier than the cycle after handshake.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_beat && w_vec_end) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    //--------------------------------------------------------------------------
    // Slot counter and packed vector registers. The slot-0 beat clears every
    // other slot so a short (in_last) vector or a vector following a reset
    // never carries stale elements from an earlier vector.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_x    <= '0;
            r_w    <= '0;
            r_b    <= '0;
        end else if (w_beat) begin
            r_slot <= w_vec_end ? '0 : r_slot + 1'b1;
            if (r_slot == '0) begin
                r_b <= in_b;
            end
            for (int i = 0; i < N; i++) begin
                if (r_slot == CNT_WIDTH'(i)) begin
                    r_x[i*DATA_WIDTH +: DATA_WIDTH] <= in_x;
                    r_w[i*DATA_WIDTH +: DATA_WIDTH] <= in_w;
                end else if (r_slot == '0) begin
                    r_x[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    r_w[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
            end
        end
    end

    assign out_x = r_x;
    assign out_w = r_w;
    assign out_b = r_b;

endmodule

`default_nettype wire

// File: tb/tb_vector_packer.sv
//==============================================================================
// Module   : tb_vector_packer
// Purpose  : Directed self-checking bench for vector_packer (N=4, 8-bit).
// Config   : VECTOR_PACKER_TLAST_EN - also exercises the early-end beat
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_vector_packer;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic [DW-1:0] in_w;
    logic [DW-1:0] in_b;
`ifdef VECTOR_PACKER_TLAST_EN
    logic          in_last;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [N*DW-1:0] out_x;
    logic [N*DW-1:0] out_w;
    logic [DW-1:0]   out_b;

    int tests;
    int fails;

    vector_packer #(
        .N          (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_b      (in_b),
`ifdef VECTOR_PACKER_TLAST_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_w     (out_w),
        .out_b     (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one cycle; the packer must be ready.
    task automatic beat(input logic [DW-1:0] x, input logic [DW-1:0] w,
                        input logic [DW-1:0] b, input logic last);
        chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_b     = b;
`ifdef VECTOR_PACKER_TLAST_EN
        in_last  = last;
`else
        if (last) $display("[TB] in_last ignored in this build");
`endif
        tick();
        in_valid = 1'b0;
`ifdef VECTOR_PACKER_TLAST_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_vec(input string tag, input logic [31:0] ex,
                           input logic [31:0] ew, input logic [7:0] eb);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_out_x"}, out_x, ex);
        chk({tag, "_out_w"}, out_w, ew);
        chk({tag, "_out_b"}, {24'd0, out_b}, {24'd0, eb});
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_b      = '0;
`ifdef VECTOR_PACKER_TLAST_EN
        in_last   = 1'b0;
`endif
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_w", out_w, 32'd0);
        chk("rst_out_b", {24'd0, out_b}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Basic back-to-back vector
        beat(8'h01, 8'hFF, 8'h05, 1'b0);
        beat(8'h02, 8'hFE, 8'h00, 1'b0);
        chk("basic_mid_out_valid", {31'd0, out_valid}, 32'd0);
        beat(8'h03, 8'hFD, 8'h00, 1'b0);
        beat(8'h04, 8'hFC, 8'h00, 1'b0);
        chk_vec("basic", 32'h04030201, 32'hFCFDFEFF, 8'h05);

        // Backpressure: beats offered while FULL must not be consumed
        in_valid = 1'b1;
        in_x     = 8'hAA;
        in_w     = 8'hBB;
        in_b     = 8'hCC;
        for (int c = 0; c < 5; c++) tick();
        chk_vec("bp_hold", 32'h04030201, 32'hFCFDFEFF, 8'h05);
        in_x      = 8'h11;
        in_w      = 8'h22;
        in_b      = 8'h33;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_x", out_x, 32'h04030201);
        tick();
        in_valid = 1'b0;
        chk("bp_slot0_out_x", out_x, 32'h00000011);
        chk("bp_slot0_out_w", out_w, 32'h00000022);
        chk("bp_slot0_out_b", {24'd0, out_b}, 32'h00000033);
        beat(8'h12, 8'h23, 8'h77, 1'b0);
        beat(8'h13, 8'h24, 8'h77, 1'b0);
        beat(8'h14, 8'h25, 8'h77, 1'b0);
        chk_vec("bp_vec", 32'h14131211, 32'h25242322, 8'h33);
        drain();

        // Gapped input: one idle cycle between beats
        beat(8'h01, 8'hFF, 8'h05, 1'b0);
        tick();
        beat(8'h02, 8'hFE, 8'h00, 1'b0);
        tick();
        chk("gap_mid_out_valid", {31'd0, out_valid}, 32'd0);
        beat(8'h03, 8'hFD, 8'h00, 1'b0);
        tick();
        beat(8'h04, 8'hFC, 8'h00, 1'b0);
        chk_vec("gap", 32'h04030201, 32'hFCFDFEFF, 8'h05);
        drain();

        // Reset mid-fill discards the partial vector
        beat(8'h55, 8'h66, 8'h77, 1'b0);
        beat(8'h55, 8'h66, 8'h77, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_x", out_x, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) beat(8'h09, 8'h01, 8'h00, 1'b0);
        chk_vec("midrst_vec", 32'h09090909, 32'h01010101, 8'h00);
        drain();

`ifdef VECTOR_PACKER_TLAST_EN
        // Early end of vector after two beats
        beat(8'h07, 8'h01, 8'h03, 1'b0);
        beat(8'h08, 8'h02, 8'h00, 1'b1);
        chk_vec("tlast", 32'h00000807, 32'h00000201, 8'h03);
        drain();
        // Single-beat vector ending on slot 0
        beat(8'h3C, 8'h5A, 8'h7E, 1'b1);
        chk_vec("tlast_slot0", 32'h0000003C, 32'h0000005A, 8'h7E);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
